vector_exec_dispatcher: RTL and testbench
=========================================

Name: vector_exec_dispatcher

Overview:
- Initiator side of the vector function unit (VFU) execute/status protocol. Sits between vector decode/operand-read and the VFU.
- Accepts one decoded vector arithmetic instruction with its operands, then launches it on the VFU with a one-cycle execute pulse.
- Tracks VFU status through NOP, WORKING and FINISHED, and captures the raw result.
- Merges the result with the old destination value (mask-undisturbed, tail-undisturbed) and delivers the merged vector to the vector register file over a valid/ready writeback handshake.

Parameters:
- LEN, 32, scalar word width
- VECTOR_SIZE, 8, words per vector register; VLEN = VECTOR_SIZE*LEN
- ENTRY_INDEX_SIZE, 3, element-count index width; length port is ENTRY_INDEX_SIZE+1 bits
- TIMEOUT, 64, maximum cycles allowed in WAIT_DONE before the error flag is raised

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy_in  in  1  global enable; when 0, all state and outputs hold
- issue_valid  in  1  instruction and operands present
- issue_ready  out  1  dispatcher can accept; high only in IDLE
- vsew  in  3  source SEW encoding (ONE_BYTE..EIGHT_BYTE)
- vm  in  1  1 = unmasked
- length  in  ENTRY_INDEX_SIZE+1  vl
- vs1, vs2, mask, old_vd  in  VLEN each  operands and prior destination value
- imm, rs  in  LEN each  immediate and scalar operand
- alu_signal  in  3  passed to VFU
- vec_operand_type  in  2  passed to VFU
- ext_type  in  5  passed to VFU
- funct6  in  6  passed to VFU
- vd_index  in  5  destination register
- fu_execute  out  1  launch pulse to VFU
- fu_* (vsew, vm, length, vs1, vs2, mask, imm, rs, alu_signal, vec_operand_type, ext_type, funct6)  out  same widths as inputs  registered copies driven to the VFU
- fu_result  in  VLEN  VFU result
- fu_status  in  2  VEC_ALU_NOP / VEC_ALU_WORKING / VEC_ALU_FINISHED
- wb_valid  out  1  writeback request
- wb_ready  in  1  register file accepts
- wb_vd  out  5  destination index
- wb_data  out  VLEN  merged result
- err  out  1  sticky error: timeout, or length over capacity; cleared only by rst

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, issue_ready=1, fu_execute=0, wb_valid=0, err=0
  - all data registers cleared to 0; watchdog counter=0
- Reset mid-operation aborts without writeback. The VFU is assumed reset by the same rst.
- If rdy_in=0: no state, counter or output changes.
- IDLE:
  - Latches all inputs when issue_valid && issue_ready.
  - Decodes destination EEW (widening/zext/sext scale it) and the mask-op flag from funct6, vec_operand_type and ext_type using the shared decode sub-module.
  - If length==0: go to WRITEBACK with wb_data=old_vd. The VFU is never launched.
  - Else if length > VLEN/EEW: set err, drop the instruction, stay in IDLE.
  - Else: go to LAUNCH.
- LAUNCH:
  - Waits until fu_status is NOP or FINISHED, then asserts fu_execute for exactly 1 cycle.
  - Goes to WAIT_BUSY.
- WAIT_BUSY:
  - Expects fu_status==WORKING on the next cycle, then goes to WAIT_DONE.
  - If fu_status is still NOP, re-launches once via LAUNCH; a second failure sets err and returns to IDLE.
- WAIT_DONE:
  - Counter increments each cycle.
  - On fu_status==FINISHED, captures fu_result in that same cycle (FINISHED lasts one cycle) and goes to MERGE.
  - If the counter reaches TIMEOUT: set err, go to IDLE, no writeback.
- MERGE (1 cycle), per element i of width EEW:
  - i<length and (vm || mask[i]): take the result element.
  - otherwise: keep the old_vd element.
  - For mask ops, elements are single bits at bit i, same rule.
  - Goes to WRITEBACK.
- WRITEBACK:
  - wb_valid=1; wb_vd and wb_data remain stable until wb_ready.
  - On the handshake: wb_valid drops next cycle, go to IDLE, issue_ready=1.
- Latency: issue to first wb_valid = 1 (LAUNCH) + VFU cycles + 1 (MERGE) + 1.
- Back-to-back instructions:
  - A new issue is accepted the cycle after the writeback handshake.
  - The new launch may coincide with the VFU holding FINISHED; this is legal, since the VFU relaunches from FINISHED.

Decomposition:
- Shared defines: VEC_ALU_* status codes, SEW encodings, V_* funct6 codes, ZEXT/SEXT codes, dispatcher state codes.
- One sub-module: vector_opcode_decode (combinational). Maps funct6, vec_operand_type, ext_type and vsew to destination EEW and the is_mask_op flag. The team reuses it in the VFU to remove its duplicated decode.

Test Plan:
- VADD, SEW=32, vl=8, vm=1, vs1[i]=i, vs2[i]=10 -> one fu_execute pulse; wb_data[i]=10+i; wb_vd equals the issued vd_index.
- VADD, SEW=32, vl=5, vm=0, mask=8'b0001_0101, old_vd all 0xFFFFFFFF -> elements 0, 2, 4 take the sum; elements 1, 3, 5..7 are 0xFFFFFFFF.
- VMADC, SEW=8, vl=4, operands 0xFF+0x01 in every element -> wb_data bits[3:0]=4'b1111; bits above 3 equal old_vd.
- vl=0 -> fu_execute never asserted; wb_data=old_vd on the cycle after acceptance.
- VFU model stuck in WORKING -> err=1 after TIMEOUT=64 cycles, no wb_valid, issue_ready=1.
- wb_ready held 0 for 5 cycles -> wb_data stable throughout; rst asserted in WAIT_DONE -> next cycle IDLE, wb_valid=0, err=0.

Source files
------------

// File: rtl/vector_exec_dispatcher_pkg.sv
// Shared constants for the vector execute dispatcher and the VFU:
// status codes, SEW/operand-type encodings, funct6 and extension codes, FSM states.
package vector_exec_dispatcher_pkg;

   // VFU status
   localparam logic [1:0] VEC_ALU_NOP      = 2'd0;
   localparam logic [1:0] VEC_ALU_WORKING  = 2'd1;
   localparam logic [1:0] VEC_ALU_FINISHED = 2'd2;

   // Source SEW encodings (value is log2 of the element size in bytes)
   localparam logic [2:0] ONE_BYTE   = 3'd0;
   localparam logic [2:0] TWO_BYTE   = 3'd1;
   localparam logic [2:0] FOUR_BYTE  = 3'd2;
   localparam logic [2:0] EIGHT_BYTE = 3'd3;

   // Operand categories
   localparam logic [1:0] OPIVV = 2'd0;
   localparam logic [1:0] OPIVX = 2'd1;
   localparam logic [1:0] OPIVI = 2'd2;
   localparam logic [1:0] OPMVV = 2'd3;

   // funct6 codes used by the decode
   localparam logic [5:0] V_ADD     = 6'b000000;
   localparam logic [5:0] V_SUB     = 6'b000010;
   localparam logic [5:0] V_MADC    = 6'b010001;
   localparam logic [5:0] V_MSBC    = 6'b010011;
   localparam logic [5:0] V_XUNARY0 = 6'b010010;  // zext/sext when OPMVV
   localparam logic [5:0] V_MSEQ    = 6'b011000;
   localparam logic [5:0] V_MSLT    = 6'b011011;
   localparam logic [5:0] V_WADDU   = 6'b110000;
   localparam logic [5:0] V_WADD    = 6'b110001;

   // Integer extension codes carried in ext_type
   localparam logic [4:0] ZEXT_VF8 = 5'b00010;
   localparam logic [4:0] SEXT_VF8 = 5'b00011;
   localparam logic [4:0] ZEXT_VF4 = 5'b00100;
   localparam logic [4:0] SEXT_VF4 = 5'b00101;
   localparam logic [4:0] ZEXT_VF2 = 5'b00110;
   localparam logic [4:0] SEXT_VF2 = 5'b00111;

   // Dispatcher states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_MERGE     = 3'd4,
      ST_WRITEBACK = 3'd5
   } disp_state_t;

endpackage

// File: rtl/vector_opcode_decode.sv
// Combinational decode of destination element width and mask-op flag.
// eew_log2 is log2 of the destination element size in bytes; mask ops report the
// source SEW because their element count is bounded by the source operands.
module vector_opcode_decode
   import vector_exec_dispatcher_pkg::*;
(
   input  logic [5:0] funct6,
   input  logic [1:0] vec_operand_type,
   input  logic [4:0] ext_type,
   input  logic [2:0] vsew,
   output logic [2:0] eew_log2,
   output logic       is_mask_op
);

   logic       is_widen;
   logic       is_ext;
   logic       is_compare;
   logic       is_carry_mask;
   logic [2:0] scale;

   // Classify the opcode and scale the source width for widening/extension ops
   always_comb begin
      is_widen      = (vec_operand_type == OPMVV) && (funct6[5:4] == 2'b11);
      is_ext        = (vec_operand_type == OPMVV) && (funct6 == V_XUNARY0);
      is_compare    = (vec_operand_type != OPMVV) && (funct6[5:3] == 3'b011);
      is_carry_mask = (vec_operand_type != OPMVV) && ((funct6 == V_MADC) || (funct6 == V_MSBC));
      is_mask_op    = is_compare || is_carry_mask;
      scale         = 3'd0;
      if (is_widen) begin
         scale = 3'd1;
      end else if (is_ext) begin
         case (ext_type)
            ZEXT_VF2, SEXT_VF2: scale = 3'd1;
            ZEXT_VF4, SEXT_VF4: scale = 3'd2;
            ZEXT_VF8, SEXT_VF8: scale = 3'd3;
            default:            scale = 3'd0;
         endcase
      end
      // Reserved SEW encodings map to an impossible width so capacity becomes zero
      eew_log2 = vsew[2] ? 3'd7 : (vsew + scale);
   end

endmodule

// File: rtl/vector_exec_dispatcher.sv
// Issues one decoded vector instruction to the VFU, tracks its status, merges the
// result with the old destination (mask/tail undisturbed) and writes it back.
module vector_exec_dispatcher
   import vector_exec_dispatcher_pkg::*;
#(
   parameter int LEN              = 32,
   parameter int VECTOR_SIZE      = 8,
   parameter int ENTRY_INDEX_SIZE = 3,
   parameter int TIMEOUT          = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rdy_in,
   input  logic                        issue_valid,
   output logic                        issue_ready,
   input  logic [2:0]                  vsew,
   input  logic                        vm,
   input  logic [ENTRY_INDEX_SIZE:0]   length,
   input  logic [VECTOR_SIZE*LEN-1:0]  vs1,
   input  logic [VECTOR_SIZE*LEN-1:0]  vs2,
   input  logic [VECTOR_SIZE*LEN-1:0]  mask,
   input  logic [VECTOR_SIZE*LEN-1:0]  old_vd,
   input  logic [LEN-1:0]              imm,
   input  logic [LEN-1:0]              rs,
   input  logic [2:0]                  alu_signal,
   input  logic [1:0]                  vec_operand_type,
   input  logic [4:0]                  ext_type,
   input  logic [5:0]                  funct6,
   input  logic [4:0]                  vd_index,
   output logic                        fu_execute,
   output logic [2:0]                  fu_vsew,
   output logic                        fu_vm,
   output logic [ENTRY_INDEX_SIZE:0]   fu_length,
   output logic [VECTOR_SIZE*LEN-1:0]  fu_vs1,
   output logic [VECTOR_SIZE*LEN-1:0]  fu_vs2,
   output logic [VECTOR_SIZE*LEN-1:0]  fu_mask,
   output logic [LEN-1:0]              fu_imm,
   output logic [LEN-1:0]              fu_rs,
   output logic [2:0]                  fu_alu_signal,
   output logic [1:0]                  fu_vec_operand_type,
   output logic [4:0]                  fu_ext_type,
   output logic [5:0]                  fu_funct6,
   input  logic [VECTOR_SIZE*LEN-1:0]  fu_result,
   input  logic [1:0]                  fu_status,
   output logic                        wb_valid,
   input  logic                        wb_ready,
   output logic [4:0]                  wb_vd,
   output logic [VECTOR_SIZE*LEN-1:0]  wb_data,
   output logic                        err
);

   localparam int VLEN   = VECTOR_SIZE * LEN;
   localparam int NBYTES = VLEN / 8;
   localparam int EW     = $clog2(VLEN);        // element index width
   localparam int IW     = EW + 1;              // capacity width (holds NBYTES)
   localparam int CW     = $clog2(TIMEOUT + 1); // watchdog width

   disp_state_t         state_reg;
   logic                issue_ready_reg;
   logic                fu_execute_reg;
   logic                wb_valid_reg;
   logic                err_reg;
   logic                retry_reg;
   logic [CW-1:0]       cnt_reg;
   logic [2:0]          eew_reg;
   logic                mask_op_reg;
   logic [4:0]          vd_reg;
   logic [VLEN-1:0]     old_vd_reg;
   logic [VLEN-1:0]     result_reg;
   logic [VLEN-1:0]     wb_data_reg;
   logic [2:0]          vsew_reg;
   logic                vm_reg;
   logic [ENTRY_INDEX_SIZE:0] length_reg;
   logic [VLEN-1:0]     vs1_reg;
   logic [VLEN-1:0]     vs2_reg;
   logic [VLEN-1:0]     mask_reg;
   logic [LEN-1:0]      imm_reg;
   logic [LEN-1:0]      rs_reg;
   logic [2:0]          alu_signal_reg;
   logic [1:0]          vec_operand_type_reg;
   logic [4:0]          ext_type_reg;
   logic [5:0]          funct6_reg;

   logic [2:0]          dec_eew;
   logic                dec_mask_op;
   logic [IW-1:0]       capacity;
   logic                len_over;
   logic [VLEN-1:0]     merged_data;
   logic [VLEN-1:0]     merged_mask;

   vector_opcode_decode u_decode (
      .funct6           (funct6),
      .vec_operand_type (vec_operand_type),
      .ext_type         (ext_type),
      .vsew             (vsew),
      .eew_log2         (dec_eew),
      .is_mask_op       (dec_mask_op)
   );

   // Element capacity of one register at the decoded width
   assign capacity = IW'(NBYTES) >> dec_eew;
   assign len_over = IW'(length) > capacity;

   // Byte-lane merge for ordinary ops: each byte follows the element it belongs to
   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_byte
         logic [EW-1:0] elem_idx;
         logic          take;
         assign elem_idx = EW'(gi) >> eew_reg;
         assign take     = (elem_idx < EW'(length_reg)) && (vm_reg || mask_reg[elem_idx]);
         assign merged_data[gi*8 +: 8] = take ? result_reg[gi*8 +: 8] : old_vd_reg[gi*8 +: 8];
      end
      // Bit-lane merge for mask-producing ops: element i is bit i
      for (gi = 0; gi < VLEN; gi++) begin : g_bit
         logic take_bit;
         assign take_bit        = (EW'(gi) < EW'(length_reg)) && (vm_reg || mask_reg[gi]);
         assign merged_mask[gi] = take_bit ? result_reg[gi] : old_vd_reg[gi];
      end
   endgenerate

   // Control FSM with registered outputs; rdy_in low freezes everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg            <= ST_IDLE;
         issue_ready_reg      <= 1'b1;
         fu_execute_reg       <= 1'b0;
         wb_valid_reg         <= 1'b0;
         err_reg              <= 1'b0;
         retry_reg            <= 1'b0;
         cnt_reg              <= '0;
         eew_reg              <= '0;
         mask_op_reg          <= 1'b0;
         vd_reg               <= '0;
         old_vd_reg           <= '0;
         result_reg           <= '0;
         wb_data_reg          <= '0;
         vsew_reg             <= '0;
         vm_reg               <= 1'b0;
         length_reg           <= '0;
         vs1_reg              <= '0;
         vs2_reg              <= '0;
         mask_reg             <= '0;
         imm_reg              <= '0;
         rs_reg               <= '0;
         alu_signal_reg       <= '0;
         vec_operand_type_reg <= '0;
         ext_type_reg         <= '0;
         funct6_reg           <= '0;
      end else if (rdy_in) begin
         case (state_reg)
            ST_IDLE: begin
               if (issue_valid) begin
                  vsew_reg             <= vsew;
                  vm_reg               <= vm;
                  length_reg           <= length;
                  vs1_reg              <= vs1;
                  vs2_reg              <= vs2;
                  mask_reg             <= mask;
                  old_vd_reg           <= old_vd;
                  imm_reg              <= imm;
                  rs_reg               <= rs;
                  alu_signal_reg       <= alu_signal;
                  vec_operand_type_reg <= vec_operand_type;
                  ext_type_reg         <= ext_type;
                  funct6_reg           <= funct6;
                  vd_reg               <= vd_index;
                  eew_reg              <= dec_eew;
                  mask_op_reg          <= dec_mask_op;
                  retry_reg            <= 1'b0;
                  cnt_reg              <= '0;
                  if (length == '0) begin
                     // Nothing to compute: write the old value straight back
                     wb_data_reg     <= old_vd;
                     wb_valid_reg    <= 1'b1;
                     issue_ready_reg <= 1'b0;
                     state_reg       <= ST_WRITEBACK;
                  end else if (len_over) begin
                     err_reg <= 1'b1;
                  end else begin
                     issue_ready_reg <= 1'b0;
                     state_reg       <= ST_LAUNCH;
                  end
               end
            end
            ST_LAUNCH: begin
               if ((fu_status == VEC_ALU_NOP) || (fu_status == VEC_ALU_FINISHED)) begin
                  fu_execute_reg <= 1'b1;
                  state_reg      <= ST_WAIT_BUSY;
               end
            end
            ST_WAIT_BUSY: begin
               // First cycle ends the pulse; the VFU reports WORKING one cycle later
               if (fu_execute_reg) begin
                  fu_execute_reg <= 1'b0;
               end else if (fu_status == VEC_ALU_WORKING) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_WAIT_DONE;
               end else if (fu_status == VEC_ALU_FINISHED) begin
                  result_reg <= fu_result;
                  state_reg  <= ST_MERGE;
               end else if (!retry_reg) begin
                  retry_reg <= 1'b1;
                  state_reg <= ST_LAUNCH;
               end else begin
                  err_reg         <= 1'b1;
                  issue_ready_reg <= 1'b1;
                  state_reg       <= ST_IDLE;
               end
            end
            ST_WAIT_DONE: begin
               if (fu_status == VEC_ALU_FINISHED) begin
                  result_reg <= fu_result;
                  state_reg  <= ST_MERGE;
               end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                  err_reg         <= 1'b1;
                  issue_ready_reg <= 1'b1;
                  state_reg       <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            ST_MERGE: begin
               wb_data_reg  <= mask_op_reg ? merged_mask : merged_data;
               wb_valid_reg <= 1'b1;
               state_reg    <= ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
               if (wb_ready) begin
                  wb_valid_reg    <= 1'b0;
                  issue_ready_reg <= 1'b1;
                  state_reg       <= ST_IDLE;
               end
            end
            default: begin
               issue_ready_reg <= 1'b1;
               state_reg       <= ST_IDLE;
            end
         endcase
      end
   end

   assign issue_ready         = issue_ready_reg;
   assign fu_execute          = fu_execute_reg;
   assign fu_vsew             = vsew_reg;
   assign fu_vm               = vm_reg;
   assign fu_length           = length_reg;
   assign fu_vs1              = vs1_reg;
   assign fu_vs2              = vs2_reg;
   assign fu_mask             = mask_reg;
   assign fu_imm              = imm_reg;
   assign fu_rs               = rs_reg;
   assign fu_alu_signal       = alu_signal_reg;
   assign fu_vec_operand_type = vec_operand_type_reg;
   assign fu_ext_type         = ext_type_reg;
   assign fu_funct6           = funct6_reg;
   assign wb_valid            = wb_valid_reg;
   assign wb_vd               = vd_reg;
   assign wb_data             = wb_data_reg;
   assign err                 = err_reg;

endmodule

// File: tb/tb_vector_exec_dispatcher.sv
// Table-driven bench for vector_exec_dispatcher with a small VFU model.
`timescale 1ns/1ps
module tb_vector_exec_dispatcher;
   import vector_exec_dispatcher_pkg::*;

   localparam int VLEN = 256;

   logic            clk = 1'b0;
   logic            rst;
   logic            rdy_in;
   logic            issue_valid;
   logic            issue_ready;
   logic [2:0]      vsew;
   logic            vm;
   logic [3:0]      length;
   logic [VLEN-1:0] vs1, vs2, mask, old_vd;
   logic [31:0]     imm, rs;
   logic [2:0]      alu_signal;
   logic [1:0]      vec_operand_type;
   logic [4:0]      ext_type;
   logic [5:0]      funct6;
   logic [4:0]      vd_index;
   logic            fu_execute;
   logic [2:0]      fu_vsew;
   logic            fu_vm;
   logic [3:0]      fu_length;
   logic [VLEN-1:0] fu_vs1, fu_vs2, fu_mask;
   logic [31:0]     fu_imm, fu_rs;
   logic [2:0]      fu_alu_signal;
   logic [1:0]      fu_vec_operand_type;
   logic [4:0]      fu_ext_type;
   logic [5:0]      fu_funct6;
   logic [VLEN-1:0] fu_result;
   logic [1:0]      fu_status;
   logic            wb_valid;
   logic            wb_ready;
   logic [4:0]      wb_vd;
   logic [VLEN-1:0] wb_data;
   logic            err;

   always #5 clk = ~clk;

   vector_exec_dispatcher dut (
      .clk(clk), .rst(rst), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .vsew(vsew), .vm(vm), .length(length),
      .vs1(vs1), .vs2(vs2), .mask(mask), .old_vd(old_vd),
      .imm(imm), .rs(rs), .alu_signal(alu_signal),
      .vec_operand_type(vec_operand_type), .ext_type(ext_type),
      .funct6(funct6), .vd_index(vd_index),
      .fu_execute(fu_execute), .fu_vsew(fu_vsew), .fu_vm(fu_vm),
      .fu_length(fu_length), .fu_vs1(fu_vs1), .fu_vs2(fu_vs2),
      .fu_mask(fu_mask), .fu_imm(fu_imm), .fu_rs(fu_rs),
      .fu_alu_signal(fu_alu_signal), .fu_vec_operand_type(fu_vec_operand_type),
      .fu_ext_type(fu_ext_type), .fu_funct6(fu_funct6),
      .fu_result(fu_result), .fu_status(fu_status),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_vd(wb_vd),
      .wb_data(wb_data), .err(err)
   );

   // ---------------- VFU model ----------------
   // mode 0: normal, latency vfu_lat; 1: stuck WORKING; 2: never starts; 3: ignores first execute
   int              vfu_mode = 0;
   int              vfu_lat  = 3;
   logic [VLEN-1:0] vfu_result_val = '0;
   logic [1:0]      vfu_status;
   int              vfu_cnt;
   bit              vfu_ignored;
   int              pulses;

   always @(posedge clk) begin
      if (rst) begin
         vfu_status  <= VEC_ALU_NOP;
         vfu_cnt     <= 0;
         vfu_ignored <= 1'b0;
         pulses      <= 0;
      end else begin
         if (fu_execute) pulses <= pulses + 1;
         if (fu_execute && vfu_mode != 2 && !(vfu_mode == 3 && !vfu_ignored)) begin
            vfu_status <= VEC_ALU_WORKING;
            vfu_cnt    <= vfu_lat;
         end else begin
            if (fu_execute && vfu_mode == 3) vfu_ignored <= 1'b1;
            if (vfu_status == VEC_ALU_WORKING && vfu_mode != 1) begin
               if (vfu_cnt == 0) vfu_status <= VEC_ALU_FINISHED;
               else vfu_cnt <= vfu_cnt - 1;
            end else if (vfu_status == VEC_ALU_FINISHED) begin
               vfu_status <= VEC_ALU_NOP;
            end
         end
      end
   end

   assign fu_status = vfu_status;
   assign fu_result = (vfu_status == VEC_ALU_FINISHED) ? vfu_result_val : {8{32'hDEADBEEF}};

   // ---------------- checking helpers ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   typedef struct {
      string           name;
      logic [5:0]      f6;
      logic [1:0]      ot;
      logic [4:0]      ext;
      logic [2:0]      sew;
      logic            vm_b;
      logic [3:0]      vl;
      logic [VLEN-1:0] v1;
      logic [VLEN-1:0] v2;
      logic [VLEN-1:0] msk;
      logic [VLEN-1:0] old;
      logic [VLEN-1:0] res;
      logic [VLEN-1:0] exp_data;
      logic            exp_err;
      int              exp_pulses;
   } vec_t;

   function automatic vec_t mk(input string nm, input logic [5:0] f6, input logic [1:0] ot,
                               input logic [4:0] ex, input logic [2:0] sew, input logic vmb,
                               input logic [3:0] vl, input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                               input logic [VLEN-1:0] m, input logic [VLEN-1:0] od,
                               input logic [VLEN-1:0] r, input logic [VLEN-1:0] e,
                               input logic er, input int p);
      vec_t v;
      v.name = nm; v.f6 = f6; v.ot = ot; v.ext = ex; v.sew = sew; v.vm_b = vmb; v.vl = vl;
      v.v1 = a; v.v2 = b; v.msk = m; v.old = od; v.res = r; v.exp_data = e;
      v.exp_err = er; v.exp_pulses = p;
      return v;
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   // Present one instruction at a negedge; it is accepted on the following posedge
   task automatic issue(input vec_t v, input logic [4:0] vd);
      @(negedge clk);
      funct6 = v.f6; vec_operand_type = v.ot; ext_type = v.ext; vsew = v.sew;
      vm = v.vm_b; length = v.vl; vs1 = v.v1; vs2 = v.v2; mask = v.msk; old_vd = v.old;
      vd_index = vd; vfu_result_val = v.res;
      issue_valid = 1'b1;
      @(posedge clk);
      #1 issue_valid = 1'b0;
   endtask

   // Count negedges after acceptance until wb_valid or err, bounded
   task automatic wait_wb_or_err(input int bound, output int n, output bit got_wb);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (n < bound && !wb_valid && !err);
      got_wb = wb_valid;
   endtask

   vec_t tbl[12];
   int   n;
   bit   got_wb;
   logic [VLEN-1:0] seq_vs1;
   logic [VLEN-1:0] ten_vs2;
   logic [VLEN-1:0] sum_res;
   logic [VLEN-1:0] allf;

   initial begin
      rst = 1'b1; rdy_in = 1'b1; issue_valid = 1'b0; wb_ready = 1'b1;
      vsew = '0; vm = 1'b0; length = '0; vs1 = '0; vs2 = '0; mask = '0; old_vd = '0;
      imm = 32'h0000_0011; rs = 32'h0000_0022; alu_signal = 3'd5;
      vec_operand_type = '0; ext_type = '0; funct6 = '0; vd_index = '0;

      seq_vs1 = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
      ten_vs2 = {8{32'd10}};
      sum_res = {32'd17, 32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10};
      allf    = {8{32'hFFFF_FFFF}};

      tbl[0]  = mk("vadd_full", V_ADD, OPIVV, 5'd0, FOUR_BYTE, 1'b1, 4'd8, seq_vs1, ten_vs2, '0, allf,
                   sum_res, {32'd17, 32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10}, 1'b0, 1);
      tbl[1]  = mk("vadd_masked", V_ADD, OPIVV, 5'd0, FOUR_BYTE, 1'b0, 4'd5, seq_vs1, ten_vs2,
                   256'h15, allf, sum_res,
                   {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd14, 32'hFFFF_FFFF, 32'd12,
                    32'hFFFF_FFFF, 32'd10}, 1'b0, 1);
      tbl[2]  = mk("vmadc_sew8", V_MADC, OPIVV, 5'd0, ONE_BYTE, 1'b1, 4'd4, {32{8'hFF}}, {32{8'h01}},
                   '0, {8{32'hA5A5_A5A5}}, {VLEN{1'b1}},
                   {{7{32'hA5A5_A5A5}}, 32'hA5A5_A5AF}, 1'b0, 1);
      tbl[3]  = mk("vl_zero", V_ADD, OPIVV, 5'd0, FOUR_BYTE, 1'b1, 4'd0, seq_vs1, ten_vs2, '0,
                   {32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004,
                    32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000}, sum_res,
                   {32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004,
                    32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000}, 1'b0, 0);
      tbl[4]  = mk("vadd_over", V_ADD, OPIVV, 5'd0, FOUR_BYTE, 1'b1, 4'd9, seq_vs1, ten_vs2, '0, allf,
                   sum_res, '0, 1'b1, 0);
      tbl[5]  = mk("vwaddu_sew16", V_WADDU, OPMVV, 5'd0, TWO_BYTE, 1'b1, 4'd5, seq_vs1, ten_vs2, '0,
                   {8{32'h0BAD_0BAD}},
                   {32'hC000_0007, 32'hC000_0006, 32'hC000_0005, 32'hC000_0004,
                    32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000},
                   {32'h0BAD_0BAD, 32'h0BAD_0BAD, 32'h0BAD_0BAD, 32'hC000_0004,
                    32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000}, 1'b0, 1);
      tbl[6]  = mk("vwadd_over", V_WADD, OPMVV, 5'd0, TWO_BYTE, 1'b1, 4'd9, seq_vs1, ten_vs2, '0, allf,
                   sum_res, '0, 1'b1, 0);
      tbl[7]  = mk("vzext_vf4", V_XUNARY0, OPMVV, ZEXT_VF4, ONE_BYTE, 1'b0, 4'd3, seq_vs1, '0,
                   256'h6, {8{32'h5555_5555}},
                   {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0},
                   {32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555,
                    32'h5555_5555, 32'hA2, 32'hA1, 32'h5555_5555}, 1'b0, 1);
      tbl[8]  = mk("vadd_sew8_vl15", V_ADD, OPIVV, 5'd0, ONE_BYTE, 1'b1, 4'd15, seq_vs1, ten_vs2, '0,
                   {32{8'hC3}}, {32{8'h3C}}, {{17{8'hC3}}, {15{8'h3C}}}, 1'b0, 1);
      tbl[9]  = mk("vmseq_masked", V_MSEQ, OPIVV, 5'd0, FOUR_BYTE, 1'b0, 4'd8, seq_vs1, seq_vs1,
                   256'hA6, '0, {VLEN{1'b1}}, 256'hA6, 1'b0, 1);
      tbl[10] = mk("vmslt_over", V_MSLT, OPIVX, 5'd0, FOUR_BYTE, 1'b1, 4'd9, seq_vs1, ten_vs2, '0, '0,
                   '0, '0, 1'b1, 0);
      tbl[11] = mk("vsext_vf8_over", V_XUNARY0, OPMVV, SEXT_VF8, ONE_BYTE, 1'b1, 4'd5, seq_vs1, '0, '0,
                   '0, '0, '0, 1'b1, 0);

      // ---- reset state ----
      apply_reset();
      check("reset_issue_ready", VLEN'(issue_ready), VLEN'(1'b1));
      check("reset_fu_execute", VLEN'(fu_execute), VLEN'(1'b0));
      check("reset_wb_valid", VLEN'(wb_valid), VLEN'(1'b0));
      check("reset_err", VLEN'(err), VLEN'(1'b0));
      check("reset_wb_data", wb_data, '0);
      $display("txn reset checked");

      // ---- table-driven vectors ----
      for (int i = 0; i < 12; i++) begin
         apply_reset();
         vfu_mode = 0;
         wb_ready = 1'b1;
         issue(tbl[i], 5'(i + 3));
         wait_wb_or_err(300, n, got_wb);
         if (tbl[i].exp_err) begin
            check({tbl[i].name, "_err"}, VLEN'(err), VLEN'(1'b1));
            check({tbl[i].name, "_no_wb"}, VLEN'(got_wb), VLEN'(1'b0));
            check({tbl[i].name, "_issue_ready"}, VLEN'(issue_ready), VLEN'(1'b1));
            check({tbl[i].name, "_pulses"}, VLEN'(pulses), VLEN'(tbl[i].exp_pulses));
         end else begin
            check({tbl[i].name, "_wb_seen"}, VLEN'(got_wb), VLEN'(1'b1));
            check({tbl[i].name, "_wb_data"}, wb_data, tbl[i].exp_data);
            check({tbl[i].name, "_wb_vd"}, VLEN'(wb_vd), VLEN'(5'(i + 3)));
            check({tbl[i].name, "_pulses"}, VLEN'(pulses), VLEN'(tbl[i].exp_pulses));
            check({tbl[i].name, "_err"}, VLEN'(err), VLEN'(1'b0));
            if (tbl[i].vl == 4'd0) check({tbl[i].name, "_latency"}, VLEN'(n), VLEN'(1));
            if (tbl[i].exp_pulses > 0) begin
               check({tbl[i].name, "_fu_ctrl"},
                     VLEN'({fu_funct6, fu_vec_operand_type, fu_ext_type, fu_vsew, fu_vm, fu_length,
                            fu_alu_signal, fu_imm, fu_rs}),
                     VLEN'({tbl[i].f6, tbl[i].ot, tbl[i].ext, tbl[i].sew, tbl[i].vm_b, tbl[i].vl,
                            3'd5, 32'h0000_0011, 32'h0000_0022}));
               check({tbl[i].name, "_fu_vs1"}, fu_vs1, tbl[i].v1);
               check({tbl[i].name, "_fu_vs2"}, fu_vs2, tbl[i].v2);
               check({tbl[i].name, "_fu_mask"}, fu_mask, tbl[i].msk);
            end
            @(negedge clk);
            check({tbl[i].name, "_wb_release"}, VLEN'({wb_valid, issue_ready}), VLEN'(2'b01));
         end
         $display("txn %0d %s cycles=%0d wb=%0d err=%0d", i, tbl[i].name, n, got_wb, err);
      end

      // ---- VFU stuck in WORKING: watchdog ----
      apply_reset();
      vfu_mode = 1;
      issue(tbl[0], 5'd1);
      wait_wb_or_err(200, n, got_wb);
      check("timeout_err", VLEN'(err), VLEN'(1'b1));
      check("timeout_no_wb", VLEN'(got_wb), VLEN'(1'b0));
      check("timeout_issue_ready", VLEN'(issue_ready), VLEN'(1'b1));
      check("timeout_window", VLEN'((n >= 64) && (n <= 68)), VLEN'(1'b1));
      $display("txn timeout cycles=%0d err=%0d", n, err);

      // ---- VFU never starts: one retry then error ----
      apply_reset();
      vfu_mode = 2;
      issue(tbl[0], 5'd2);
      wait_wb_or_err(60, n, got_wb);
      check("dead_err", VLEN'(err), VLEN'(1'b1));
      check("dead_pulses", VLEN'(pulses), VLEN'(2));
      check("dead_no_wb", VLEN'(got_wb), VLEN'(1'b0));
      $display("txn dead_vfu cycles=%0d err=%0d", n, err);

      // ---- VFU misses first launch: retry succeeds ----
      apply_reset();
      vfu_mode = 3;
      issue(tbl[0], 5'd4);
      wait_wb_or_err(60, n, got_wb);
      check("retry_wb_data", wb_data, tbl[0].exp_data);
      check("retry_pulses", VLEN'(pulses), VLEN'(2));
      check("retry_err", VLEN'(err), VLEN'(1'b0));
      $display("txn retry cycles=%0d wb=%0d", n, got_wb);

      // ---- writeback back-pressure, rdy_in hold, then back-to-back issue ----
      apply_reset();
      vfu_mode = 0;
      wb_ready = 1'b0;
      issue(tbl[1], 5'd9);
      wait_wb_or_err(60, n, got_wb);
      check("stall_wb_seen", VLEN'(got_wb), VLEN'(1'b1));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_hold", {wb_valid, wb_vd, wb_data[VLEN-7:0]},
               {1'b1, 5'd9, tbl[1].exp_data[VLEN-7:0]});
      end
      rdy_in = 1'b0;
      wb_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rdy_hold", VLEN'({wb_valid, issue_ready}), VLEN'(2'b10));
      end
      rdy_in = 1'b1;
      @(negedge clk);
      check("stall_release", VLEN'({wb_valid, issue_ready}), VLEN'(2'b01));
      issue(tbl[0], 5'd10);
      wait_wb_or_err(60, n, got_wb);
      check("b2b_wb_data", wb_data, tbl[0].exp_data);
      check("b2b_wb_vd", VLEN'(wb_vd), VLEN'(5'd10));
      $display("txn stall_and_b2b cycles=%0d wb=%0d", n, got_wb);

      // ---- reset during WAIT_DONE clears a prior error and aborts ----
      apply_reset();
      issue(tbl[4], 5'd11);
      @(negedge clk);
      check("pre_rst_err", VLEN'(err), VLEN'(1'b1));
      vfu_lat = 20;
      issue(tbl[0], 5'd12);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_state", VLEN'({wb_valid, err, issue_ready, fu_execute}), VLEN'(4'b0010));
      got_wb = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (wb_valid) got_wb = 1'b1;
      end
      check("midrst_no_wb", VLEN'(got_wb), VLEN'(1'b0));
      vfu_lat = 3;
      $display("txn mid_reset wb=%0d err=%0d", got_wb, err);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
